cache_ctrl_fsm: RTL and testbench
=================================

Name: cache_ctrl_fsm

Overview:
Parametrised controller for the direct-mapped cache, next generation of the read-only tag/data/fill FSM. Adds CPU writes, write-back or write-through policy, an internal block-fill word counter in place of an external END strobe, and a per-word memory handshake. It also keeps saturating hit/miss statistics. It sits between the CPU request port, the tag/data arrays and the memory bus interface.

Parameters:
WORDS_PER_BLK, 4, words per cache block; power of two, 2 or more.
IDX_W, $clog2(WORDS_PER_BLK), width of word_idx.
WRITE_BACK, 1, 1 = write-back with dirty bits; 0 = write-through.
STAT_W, 16, width of the hit/miss counters.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
cpu_req  in  1  CPU request valid; held until cpu_ready.
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
hit  in  1  tag comparison match for the current index.
valid  in  1  valid bit of the indexed line.
dirty  in  1  dirty bit of the indexed line; ignored when WRITE_BACK = 0.
mem_ready  in  1  memory accepted or returned the current word this cycle.
cpu_ready  out  1  one-cycle pulse: request complete.
tag_wr  out  1  write tag, set valid.
data_wr  out  1  write one data word at word_idx.
fill_sel  out  1  1 = data array source is memory, 0 = CPU.
dirty_set  out  1  set dirty bit of the line.
dirty_clr  out  1  clear dirty bit of the line.
mem_rd  out  1  memory read request for word word_idx.
mem_wr  out  1  memory write request for word word_idx, or the CPU word in WT state.
word_idx  out  IDX_W  word offset during WB/FILL; 0 otherwise.
busy  out  1  state is not IDLE.
hit_cnt  out  STAT_W  saturating count of hits.
miss_cnt  out  STAT_W  saturating count of misses.

Behaviour:
- Reset (asynchronous): state = IDLE, word counter = 0, hit_cnt = 0, miss_cnt = 0. All outputs 0. A reset mid-WB/FILL abandons the transfer with no further memory strobes.
- States: IDLE, COMPARE, WB, FILL, UPD_TAG, WT.
- IDLE: if cpu_req, go to COMPARE next cycle.
- COMPARE, hit = hit & valid:
  - Read hit: cpu_ready = 1, go to IDLE.
  - Write hit with WRITE_BACK = 1: data_wr = 1, fill_sel = 0, dirty_set = 1, cpu_ready = 1, go to IDLE.
  - Write hit with WRITE_BACK = 0: data_wr = 1, go to WT.
  - Miss: if WRITE_BACK & valid & dirty, go to WB; otherwise go to FILL.
  - hit_cnt increments on a hit, miss_cnt on a miss. Both saturate at all-ones. The re-entry into COMPARE after UPD_TAG is not counted.
- WB: mem_wr = 1. On mem_ready the counter increments. On mem_ready with counter = WORDS_PER_BLK-1, the counter wraps to 0 and the FSM goes to FILL.
- FILL: mem_rd = 1, fill_sel = 1, data_wr = mem_ready (Mealy). The counter advances on mem_ready. On the last word, the counter wraps to 0 and the FSM goes to UPD_TAG.
- UPD_TAG: tag_wr = 1, dirty_clr = 1, go to COMPARE. COMPARE then sees a hit and completes the original read or write.
- WT: mem_wr = 1 and word_idx = 0 (the CPU word is sent); hold until mem_ready, then cpu_ready = 1 and go to IDLE.
- mem_ready is ignored outside WB, FILL and WT.
- cpu_ready is never asserted in the same cycle as mem_rd or mem_wr, except the final WT cycle.
- cpu_req dropped mid-transaction is a protocol violation; the FSM still completes the sequence.
- Latency with mem_ready always high:
  - Read hit: 2 cycles from cpu_req to cpu_ready.
  - Clean miss: 2 + WORDS_PER_BLK + 2 cycles.
  - Dirty miss: adds WORDS_PER_BLK cycles.
- Outputs are combinational from state, the counter and inputs. State, counter and statistics are registered.

Test Plan:
- Reset asserted mid-FILL (word_idx = 2), asynchronous to clk -> immediately state IDLE, word_idx = 0, mem_rd = 0, busy = 0, counters 0.
- Read hit (hit = 1, valid = 1, cpu_we = 0) -> cpu_ready pulse in the 2nd cycle; no data_wr or mem_*; hit_cnt = 1.
- Clean read miss, WORDS_PER_BLK = 4, mem_ready stalled low 1 cycle per word -> 4 data_wr pulses with word_idx 0,1,2,3, then tag_wr + dirty_clr, then cpu_ready; miss_cnt = 1, hit_cnt = 0.
- Dirty write miss, WRITE_BACK = 1 -> 4 mem_wr beats (idx 0..3), then 4 fills, then UPD_TAG, then data_wr with fill_sel = 0 + dirty_set + cpu_ready.
- WRITE_BACK = 0 write hit, mem_ready after 3 cycles -> data_wr in COMPARE, mem_wr held 3 cycles, then cpu_ready; dirty_set never asserted.
- STAT_W = 2, 5 consecutive read hits -> hit_cnt saturates at 3.

Source files
------------

// File: rtl/cache_ctrl_fsm_if.sv
// CPU request, tag/data array and memory handshake bundle for cache_ctrl_fsm.
// The master side is the environment (CPU, arrays, memory); the slave side is the controller.
interface cache_ctrl_fsm_if #(
    parameter int IDX_W  = 2,
    parameter int STAT_W = 16
);
    // CPU request port
    logic              cpu_req;
    logic              cpu_we;
    logic              cpu_ready;
    // tag/data array status and control
    logic              hit;
    logic              valid;
    logic              dirty;
    logic              tag_wr;
    logic              data_wr;
    logic              fill_sel;
    logic              dirty_set;
    logic              dirty_clr;
    // memory bus handshake
    logic              mem_ready;
    logic              mem_rd;
    logic              mem_wr;
    logic [IDX_W-1:0]  word_idx;
    // status and statistics
    logic              busy;
    logic [STAT_W-1:0] hit_cnt;
    logic [STAT_W-1:0] miss_cnt;

    modport master (
        output cpu_req, cpu_we, hit, valid, dirty, mem_ready,
        input  cpu_ready, tag_wr, data_wr, fill_sel, dirty_set, dirty_clr,
        input  mem_rd, mem_wr, word_idx, busy, hit_cnt, miss_cnt
    );

    modport slave (
        input  cpu_req, cpu_we, hit, valid, dirty, mem_ready,
        output cpu_ready, tag_wr, data_wr, fill_sel, dirty_set, dirty_clr,
        output mem_rd, mem_wr, word_idx, busy, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/cache_ctrl_fsm.sv
// Direct-mapped cache controller: read/write hits, write-back or write-through
// policy, word-by-word write-back and block fill with a memory handshake, and
// saturating hit/miss statistics. All outputs are combinational from state,
// word counter and inputs.
module cache_ctrl_fsm #(
    parameter int WORDS_PER_BLK = 4,
    parameter int IDX_W         = $clog2(WORDS_PER_BLK),
    parameter bit WRITE_BACK    = 1'b1,
    parameter int STAT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    cache_ctrl_fsm_if.slave  bus
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] COMPARE = 3'd1;
    localparam logic [2:0] WB      = 3'd2;
    localparam logic [2:0] FILL    = 3'd3;
    localparam logic [2:0] UPD_TAG = 3'd4;
    localparam logic [2:0] WT      = 3'd5;

    localparam logic [IDX_W-1:0]  LAST_WORD = IDX_W'(WORDS_PER_BLK - 1);
    localparam logic [STAT_W-1:0] STAT_MAX  = {STAT_W{1'b1}};

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [IDX_W-1:0]  word_cnt;
    logic [IDX_W-1:0]  word_cnt_nxt;
    // Set while the COMPARE that follows a refill is pending, so it is not counted twice.
    logic              recheck;
    logic [STAT_W-1:0] hit_q;
    logic [STAT_W-1:0] miss_q;
    logic              line_hit;

    assign line_hit     = bus.hit & bus.valid;
    assign bus.hit_cnt  = hit_q;
    assign bus.miss_cnt = miss_q;
    assign bus.busy     = (state != IDLE);

    // Next-state, next-counter and Mealy/Moore output decode.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves one
        // unassigned; a missing default would infer a latch.
        state_nxt     = state;
        word_cnt_nxt  = word_cnt;
        bus.cpu_ready = 1'b0;
        bus.tag_wr    = 1'b0;
        bus.data_wr   = 1'b0;
        bus.fill_sel  = 1'b0;
        bus.dirty_set = 1'b0;
        bus.dirty_clr = 1'b0;
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.word_idx  = '0;

        case (state)
            IDLE: begin
                if (bus.cpu_req) state_nxt = COMPARE;
            end

            COMPARE: begin
                if (line_hit) begin
                    if (!bus.cpu_we) begin
                        bus.cpu_ready = 1'b1;
                        state_nxt     = IDLE;
                    end else if (WRITE_BACK) begin
                        bus.data_wr   = 1'b1;
                        bus.dirty_set = 1'b1;
                        bus.cpu_ready = 1'b1;
                        state_nxt     = IDLE;
                    end else begin
                        // Array is updated now; the same word goes to memory in WT.
                        bus.data_wr = 1'b1;
                        state_nxt   = WT;
                    end
                end else if (WRITE_BACK && bus.valid && bus.dirty) begin
                    state_nxt = WB;
                end else begin
                    state_nxt = FILL;
                end
            end

            WB: begin
                bus.mem_wr   = 1'b1;
                bus.word_idx = word_cnt;
                if (bus.mem_ready) begin
                    if (word_cnt == LAST_WORD) begin
                        word_cnt_nxt = '0;
                        state_nxt    = FILL;
                    end else begin
                        word_cnt_nxt = word_cnt + IDX_W'(1);
                    end
                end
            end

            FILL: begin
                bus.mem_rd   = 1'b1;
                bus.fill_sel = 1'b1;
                bus.word_idx = word_cnt;
                bus.data_wr  = bus.mem_ready;
                if (bus.mem_ready) begin
                    if (word_cnt == LAST_WORD) begin
                        word_cnt_nxt = '0;
                        state_nxt    = UPD_TAG;
                    end else begin
                        word_cnt_nxt = word_cnt + IDX_W'(1);
                    end
                end
            end

            UPD_TAG: begin
                bus.tag_wr    = 1'b1;
                bus.dirty_clr = 1'b1;
                state_nxt     = COMPARE;
            end

            WT: begin
                bus.mem_wr = 1'b1;
                if (bus.mem_ready) begin
                    bus.cpu_ready = 1'b1;
                    state_nxt     = IDLE;
                end
            end

            default: begin
                state_nxt    = IDLE;
                word_cnt_nxt = '0;
            end
        endcase
    end

    // State and word counter registers; reset abandons any transfer in progress.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state    <= IDLE;
            word_cnt <= '0;
        end else begin
            state    <= state_nxt;
            word_cnt <= word_cnt_nxt;
        end
    end

    // Marks the COMPARE re-entered from UPD_TAG so statistics skip it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            recheck <= 1'b0;
        end else if (state == UPD_TAG) begin
            recheck <= 1'b1;
        end else if (state == COMPARE) begin
            recheck <= 1'b0;
        end
    end

    // Saturating hit/miss counters, one count per original request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (state == COMPARE && !recheck) begin
            if (line_hit) begin
                if (hit_q != STAT_MAX) hit_q <= hit_q + STAT_W'(1);
            end else begin
                if (miss_q != STAT_MAX) miss_q <= miss_q + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Self-checking bench for cache_ctrl_fsm: a write-back instance (16-bit stats)
// and a write-through instance (2-bit stats) checked cycle by cycle against a
// transaction-level timeline model built from the controller's rules.
module tb_cache_ctrl_fsm;

    localparam int N     = 4;
    localparam int IDX_W = 2;
    localparam int MAXC  = 128;

    typedef struct packed {
        logic             cpu_ready;
        logic             tag_wr;
        logic             data_wr;
        logic             fill_sel;
        logic             dirty_set;
        logic             dirty_clr;
        logic             mem_rd;
        logic             mem_wr;
        logic             busy;
        logic [IDX_W-1:0] word_idx;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // Bench-side stimulus, shared by both instances except for the request strobe.
    logic req = 1'b0;
    logic we = 1'b0;
    logic hit_in = 1'b0;
    logic valid_in = 1'b0;
    logic dirty_in = 1'b0;
    logic rdy = 1'b0;
    int   sel = 0;

    cache_ctrl_fsm_if #(.IDX_W(IDX_W), .STAT_W(16)) bus_a ();
    cache_ctrl_fsm_if #(.IDX_W(IDX_W), .STAT_W(2))  bus_b ();

    assign bus_a.cpu_req   = req && (sel == 0);
    assign bus_a.cpu_we    = we;
    assign bus_a.hit       = hit_in;
    assign bus_a.valid     = valid_in;
    assign bus_a.dirty     = dirty_in;
    assign bus_a.mem_ready = rdy;
    assign bus_b.cpu_req   = req && (sel == 1);
    assign bus_b.cpu_we    = we;
    assign bus_b.hit       = hit_in;
    assign bus_b.valid     = valid_in;
    assign bus_b.dirty     = dirty_in;
    assign bus_b.mem_ready = rdy;

    cache_ctrl_fsm #(.WORDS_PER_BLK(N), .WRITE_BACK(1'b1), .STAT_W(16)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    cache_ctrl_fsm #(.WORDS_PER_BLK(N), .WRITE_BACK(1'b0), .STAT_W(2)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    obs_t        obs;
    logic [15:0] hit_obs;
    logic [15:0] miss_obs;

    always_comb begin
        if (sel == 1) begin
            obs = '{bus_b.cpu_ready, bus_b.tag_wr, bus_b.data_wr, bus_b.fill_sel,
                    bus_b.dirty_set, bus_b.dirty_clr, bus_b.mem_rd, bus_b.mem_wr,
                    bus_b.busy, bus_b.word_idx};
            hit_obs  = {14'b0, bus_b.hit_cnt};
            miss_obs = {14'b0, bus_b.miss_cnt};
        end else begin
            obs = '{bus_a.cpu_ready, bus_a.tag_wr, bus_a.data_wr, bus_a.fill_sel,
                    bus_a.dirty_set, bus_a.dirty_clr, bus_a.mem_rd, bus_a.mem_wr,
                    bus_a.busy, bus_a.word_idx};
            hit_obs  = bus_a.hit_cnt;
            miss_obs = bus_a.miss_cnt;
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model state.
    obs_t exp_o [MAXC];
    bit   rdy_seq [MAXC];
    int   exp_len;
    int   hit_from;
    int   m_hit [2];
    int   m_miss [2];
    int   stat_max [2];

    // One memory word transfer as seen on the bus: stall cycle or accepted beat.
    function automatic obs_t word_phase(input bit fill, input int k, input bit accepted);
        obs_t e;
        e          = '0;
        e.busy     = 1'b1;
        e.word_idx = IDX_W'(k);
        if (fill) begin
            e.mem_rd   = 1'b1;
            e.fill_sel = 1'b1;
            e.data_wr  = accepted;
        end else begin
            e.mem_wr = 1'b1;
        end
        return e;
    endfunction

    // Builds the expected per-cycle bus timeline of one request, starting at the
    // cycle cpu_req is raised, and updates the expected statistics.
    function automatic void build(input int s, input bit w, input bit h, input bit v,
                                  input bit d);
        obs_t e;
        int   t;
        bit   wb_pol;
        wb_pol    = (s == 0);
        hit_from  = MAXC;
        exp_o[0]  = '0;
        t         = 1;
        if (!(h && v)) begin
            e = '0; e.busy = 1'b1;
            exp_o[t] = e; t++;
            if (wb_pol && v && d) begin
                for (int k = 0; k < N; k++) begin
                    while (!rdy_seq[t]) begin exp_o[t] = word_phase(1'b0, k, 1'b0); t++; end
                    exp_o[t] = word_phase(1'b0, k, 1'b1); t++;
                end
            end
            for (int k = 0; k < N; k++) begin
                while (!rdy_seq[t]) begin exp_o[t] = word_phase(1'b1, k, 1'b0); t++; end
                exp_o[t] = word_phase(1'b1, k, 1'b1); t++;
            end
            e = '0; e.busy = 1'b1; e.tag_wr = 1'b1; e.dirty_clr = 1'b1;
            exp_o[t] = e; t++;
            hit_from = t;
        end
        // The (possibly second) compare now sees the line present.
        e = '0; e.busy = 1'b1;
        if (!w) begin
            e.cpu_ready = 1'b1;
            exp_o[t] = e; t++;
        end else if (wb_pol) begin
            e.data_wr = 1'b1; e.dirty_set = 1'b1; e.cpu_ready = 1'b1;
            exp_o[t] = e; t++;
        end else begin
            e.data_wr = 1'b1;
            exp_o[t] = e; t++;
            e = '0; e.busy = 1'b1; e.mem_wr = 1'b1;
            while (!rdy_seq[t]) begin exp_o[t] = e; t++; end
            e.cpu_ready = 1'b1;
            exp_o[t] = e; t++;
        end
        exp_len = t;
        if (h && v) begin
            if (m_hit[s] < stat_max[s]) m_hit[s]++;
        end else begin
            if (m_miss[s] < stat_max[s]) m_miss[s]++;
        end
    endfunction

    // Runs one request on instance s and checks every cycle plus the final statistics.
    // mode: 0 ready always, 1 one stall per word, 2 random, 3 ready from cycle 4 on.
    task automatic run_txn(input string name, input int s, input bit w, input bit h,
                           input bit v, input bit d, input int mode);
        for (int c = 0; c < MAXC; c++) begin
            case (mode)
                0:       rdy_seq[c] = 1'b1;
                1:       rdy_seq[c] = (c % 2) == 1;
                3:       rdy_seq[c] = (c >= 4);
                default: rdy_seq[c] = 1'($urandom_range(0, 1)) || ((c % 4) == 3);
            endcase
        end
        build(s, w, h, v, d);
        sel = s;
        we  = w;
        req = 1'b1;
        for (int c = 0; c < exp_len; c++) begin
            hit_in   = (c >= hit_from) ? 1'b1 : h;
            valid_in = (c >= hit_from) ? 1'b1 : v;
            dirty_in = (c >= hit_from) ? 1'b0 : d;
            rdy      = rdy_seq[c];
            @(negedge clk);
            checks++;
            if (obs !== exp_o[c]) begin
                errors++;
                $display("FAIL %s cycle %0d: outputs got %b expected %b", name, c, obs, exp_o[c]);
            end
            @(posedge clk);
            #1;
        end
        req = 1'b0;
        rdy = 1'($urandom_range(0, 1));
        @(negedge clk);
        checks++;
        if (obs !== obs_t'(0)) begin
            errors++;
            $display("FAIL %s idle_after: outputs got %b expected 0", name, obs);
        end
        checks++;
        if (hit_obs !== 16'(m_hit[s]) || miss_obs !== 16'(m_miss[s])) begin
            errors++;
            $display("FAIL %s stats: hit/miss got %0d/%0d expected %0d/%0d",
                     name, hit_obs, miss_obs, m_hit[s], m_miss[s]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_both_idle(input string name);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #0;
            #1;
            checks++;
            if (obs !== obs_t'(0) || hit_obs !== 16'd0 || miss_obs !== 16'd0) begin
                errors++;
                $display("FAIL %s dut%0d: outputs %b hit %0d miss %0d expected all 0",
                         name, s, obs, hit_obs, miss_obs);
            end
        end
    endtask

    task automatic test_reset();
        req = 1'b0;
        #1 reset = 1'b1;
        #2;
        check_both_idle("reset");
        @(negedge clk);
        reset = 1'b0;
        m_hit  = '{0, 0};
        m_miss = '{0, 0};
        @(posedge clk);
        #1;
    endtask

    task automatic test_read_hit();
        run_txn("read_hit", 0, 1'b0, 1'b1, 1'b1, 1'b0, 2);
        run_txn("read_hit_dirty", 0, 1'b0, 1'b1, 1'b1, 1'b1, 0);
    endtask

    task automatic test_clean_read_miss();
        run_txn("clean_miss_stall", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        run_txn("clean_miss_valid", 0, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        run_txn("miss_hit_invalid", 0, 1'b1, 1'b1, 1'b0, 1'b1, 0);
    endtask

    task automatic test_dirty_write_miss();
        run_txn("dirty_write_miss", 0, 1'b1, 1'b0, 1'b1, 1'b1, 0);
        run_txn("dirty_read_miss_rnd", 0, 1'b0, 1'b0, 1'b1, 1'b1, 2);
        run_txn("write_hit_wb", 0, 1'b1, 1'b1, 1'b1, 1'b0, 2);
    endtask

    // Clean miss with ready always high: FILL word 2 is on the bus in cycle 4.
    task automatic test_reset_mid_fill();
        sel = 0; we = 1'b0; hit_in = 1'b0; valid_in = 1'b0; dirty_in = 1'b0; rdy = 1'b1;
        req = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (obs.mem_rd !== 1'b1 || obs.word_idx !== 2'd2 || miss_obs === 16'd0) begin
            errors++;
            $display("FAIL reset_mid_fill pre: mem_rd %b idx %0d miss %0d expected 1 2 nonzero",
                     obs.mem_rd, obs.word_idx, miss_obs);
        end
        reset = 1'b1;
        #1;
        req = 1'b0;
        check_both_idle("reset_mid_fill");
        sel = 0;
        @(negedge clk);
        reset = 1'b0;
        m_hit  = '{0, 0};
        m_miss = '{0, 0};
        repeat (2) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs !== obs_t'(0)) begin
                errors++;
                $display("FAIL reset_mid_fill post: outputs got %b expected 0", obs);
            end
        end
    endtask

    task automatic test_write_through();
        run_txn("wt_write_hit", 1, 1'b1, 1'b1, 1'b1, 1'b0, 3);
        run_txn("wt_write_miss_dirty", 1, 1'b1, 1'b0, 1'b1, 1'b1, 2);
        run_txn("wt_read_miss", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) run_txn("sat_read_hit", 1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        for (int i = 0; i < 3; i++) run_txn("sat_miss", 1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_txn("random", int'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2);
        end
    endtask

    initial begin
        stat_max = '{65535, 3};
        m_hit    = '{0, 0};
        m_miss   = '{0, 0};
        test_reset();
        test_read_hit();
        test_clean_read_miss();
        test_dirty_write_miss();
        test_reset_mid_fill();
        test_write_through();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
